// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits + odd parity,
// stop bit, device acknowledge check, with a per-edge inactivity timeout.
`timescale 1ns/1ps
module ps2_tx #(
    parameter int unsigned INHIBIT_CYCLES = 13000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int unsigned MAX_AB = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > FILTER_LEN) ? MAX_AB : FILTER_LEN;
    localparam int unsigned CW     = $clog2(MAX_P + 1);
    localparam int unsigned FW     = $clog2(FILTER_LEN + 1);
    localparam int unsigned NW     = 4;
    localparam int unsigned FRW    = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_REL,
        S_START,
        S_DATA,
        S_ACK,
        S_WAIT,
        S_DONE
    } state_t;

    // Input path registers
    logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic          w_fall;

    // FSM state and datapath registers
    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [NW-1:0]  r_n, w_n_nxt;
    logic [FRW-1:0] r_frame, w_frame_nxt;
    logic           r_c_oe, w_c_oe_nxt;
    logic           r_d_oe, w_d_oe_nxt;
    logic           r_err, w_err_nxt;
    logic           r_idle, r_done;
    logic           w_active;

    // Synchronize both pads and glitch-filter the clock line; idle lines are high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_s1   <= 1'b1;
            r_c_s2   <= 1'b1;
            r_d_s1   <= 1'b1;
            r_d_s2   <= 1'b1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_c_s1   <= ps2c;
            r_c_s2   <= r_c_s1;
            r_d_s1   <= ps2d;
            r_d_s2   <= r_d_s1;
            r_filt_d <= r_filt;
            if (r_c_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt >= FW'(FILTER_LEN - 1)) begin
                r_filt <= r_c_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;

    // State register plus all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_frame <= '0;
            r_c_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
            r_err   <= 1'b0;
            r_idle  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_n     <= w_n_nxt;
            r_frame <= w_frame_nxt;
            r_c_oe  <= w_c_oe_nxt;
            r_d_oe  <= w_d_oe_nxt;
            r_err   <= w_err_nxt;
            r_idle  <= (w_state_nxt == S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign w_active = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_ACK)   || (r_state == S_WAIT);

    // Next-state and next-output logic; shared counter times inhibit and timeout
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '1) ? r_cnt + CW'(1) : r_cnt;
        w_n_nxt     = r_n;
        w_frame_nxt = r_frame;
        w_c_oe_nxt  = r_c_oe;
        w_d_oe_nxt  = r_d_oe;
        w_err_nxt   = r_err;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (wr_ps2) begin
                    w_frame_nxt = {~^din, din};
                    w_n_nxt     = '0;
                    w_err_nxt   = 1'b0;
                    w_c_oe_nxt  = 1'b1;
                    w_state_nxt = S_RTS;
                end
            end
            S_RTS: begin
                if (r_cnt >= CW'(INHIBIT_CYCLES - 1)) begin
                    w_d_oe_nxt  = 1'b1;
                    w_state_nxt = S_REL;
                end
            end
            S_REL: begin
                w_c_oe_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_START;
            end
            S_START, S_DATA: begin
                if (w_fall) begin
                    w_cnt_nxt = '0;
                    w_n_nxt   = r_n + NW'(1);
                    if (r_n == NW'(9)) begin
                        w_d_oe_nxt  = 1'b0;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_d_oe_nxt  = ~r_frame[r_n];
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    w_cnt_nxt   = '0;
                    w_err_nxt   = r_d_s2;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_filt && r_d_s2) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort when the device stops clocking
        if (w_active && !w_fall && (r_cnt >= CW'(TIMEOUT_CYCLES - 1))) begin
            w_c_oe_nxt  = 1'b0;
            w_d_oe_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
        end
    end

    assign ps2c_oe      = r_c_oe;
    assign ps2d_oe      = r_d_oe;
    assign tx_idle      = r_idle;
    assign tx_done_tick = r_done;
    assign tx_err       = r_err;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 device on open-collector pads.
`timescale 1ns/1ps
module tb_ps2_tx;

    localparam int HALF = 20;

    logic       clk;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c, ps2d;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;
    logic       dev_clk, dev_data;

    int n_checks;
    int n_fail;
    int done_cnt;
    int oe_run;
    int oe_last;

    assign ps2c = dev_clk  & ~ps2c_oe;
    assign ps2d = dev_data & ~ps2d_oe;

    ps2_tx #(
        .INHIBIT_CYCLES(50),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses and measure how long the host inhibits the clock line
    always @(negedge clk) begin
        if (tx_done_tick) done_cnt = done_cnt + 1;
        if (ps2c_oe) begin
            oe_run = oe_run + 1;
        end else begin
            if (oe_run != 0) oe_last = oe_run;
            oe_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    // Device waits for the host to release the clock with the start bit on data
    task automatic dev_wait_req(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 400 && !(ps2c === 1'b1 && ps2d === 1'b0 && ps2c_oe === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        if (n < 400) ok = 1'b1;
        else check("dev_req_timeout", 32'(n), 32'(0));
    endtask

    task automatic dev_clock(output logic b);
        dev_clk = 1'b0;
        cyc(HALF);
        b       = ps2d;
        dev_clk = 1'b1;
        cyc(HALF);
    endtask

    task automatic dev_frame(input logic ack, input int glitch_after,
                             output logic [7:0] rx, output logic par, output logic stp);
        bit   ok;
        logic b;
        logic [9:0] bits;
        rx   = '0;
        par  = 1'b0;
        stp  = 1'b0;
        bits = '0;
        dev_wait_req(ok);
        if (ok) begin
            cyc(10);
            for (int i = 0; i < 10; i++) begin
                dev_clock(b);
                bits[i] = b;
                if (i == glitch_after) begin
                    dev_clk = 1'b0;
                    cyc(2);
                    dev_clk = 1'b1;
                    cyc(HALF);
                end
            end
            rx  = bits[7:0];
            par = bits[8];
            stp = bits[9];
            cyc(5);
            dev_data = ack;
            cyc(5);
            dev_clock(b);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 300 && tx_idle !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_idle), 32'(1));
    endtask

    initial begin
        logic [7:0] rx;
        logic       par, stp, b;
        int         base, n;

        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        oe_run   = 0;
        oe_last  = 0;
        reset    = 1'b0;
        wr_ps2   = 1'b0;
        din      = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cyc(3);
        check("rst_c_oe", 32'(ps2c_oe), 32'(0));
        check("rst_d_oe", 32'(ps2d_oe), 32'(0));
        check("rst_idle", 32'(tx_idle), 32'(1));
        check("rst_tick", 32'(tx_done_tick), 32'(0));
        check("rst_err",  32'(tx_err), 32'(0));
        reset = 1'b1;
        cyc(5);

        // 1: 0xED, ACK; parity of six ones is 1
        base = done_cnt;
        send(8'hED);
        check("t1_idle_drop", 32'(tx_idle), 32'(0));
        dev_frame(1'b0, -1, rx, par, stp);
        wait_idle("t1_idle");
        cyc(20);
        check("t1_inhibit_ok", 32'(oe_last >= 50 && oe_last <= 51), 32'(1));
        check("t1_rx",   32'(rx), 32'hED);
        check("t1_par",  32'(par), 32'(1));
        check("t1_stop", 32'(stp), 32'(1));
        check("t1_err",  32'(tx_err), 32'(0));
        check("t1_done", 32'(done_cnt - base), 32'(1));

        // 2: 0x00 with NAK; parity of zero ones is 1
        base = done_cnt;
        send(8'h00);
        dev_frame(1'b1, -1, rx, par, stp);
        wait_idle("t2_idle");
        cyc(20);
        check("t2_rx",   32'(rx), 32'h00);
        check("t2_par",  32'(par), 32'(1));
        check("t2_err",  32'(tx_err), 32'(1));
        check("t2_done", 32'(done_cnt - base), 32'(1));

        // 3: device never clocks -> timeout about 2000 cycles after clock release
        base = done_cnt;
        send(8'hFF);
        check("t3_err_clr", 32'(tx_err), 32'(0));
        n = 0;
        while (n < 300 && ps2c_oe !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (n < 3000 && tx_done_tick !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("t3_to_window", 32'(n >= 1995 && n <= 2005), 32'(1));
        check("t3_c_oe", 32'(ps2c_oe), 32'(0));
        check("t3_d_oe", 32'(ps2d_oe), 32'(0));
        check("t3_err",  32'(tx_err), 32'(1));
        cyc(1);
        check("t3_idle", 32'(tx_idle), 32'(1));
        check("t3_done", 32'(done_cnt - base), 32'(1));

        // 4: 0xF4 with a 0x12 request mid-frame; parity of five ones is 0
        base = done_cnt;
        send(8'hF4);
        fork
            dev_frame(1'b0, -1, rx, par, stp);
            begin
                cyc(300);
                din    = 8'h12;
                wr_ps2 = 1'b1;
                cyc(1);
                wr_ps2 = 1'b0;
            end
        join
        wait_idle("t4_idle");
        cyc(100);
        check("t4_rx",   32'(rx), 32'hF4);
        check("t4_par",  32'(par), 32'(0));
        check("t4_err",  32'(tx_err), 32'(0));
        check("t4_done", 32'(done_cnt - base), 32'(1));
        check("t4_still_idle", 32'(tx_idle), 32'(1));

        // 5: reset at n=5 of 0xA5 (din[4]=0 so data is pulled low)
        send(8'hA5);
        dev_wait_req(stp);
        cyc(10);
        for (int i = 0; i < 4; i++) dev_clock(b);
        dev_clk = 1'b0;
        cyc(12);
        check("t5_d_oe_n5", 32'(ps2d_oe), 32'(1));
        base  = done_cnt;
        reset = 1'b0;
        #1;
        check("t5_c_oe", 32'(ps2c_oe), 32'(0));
        check("t5_d_oe", 32'(ps2d_oe), 32'(0));
        check("t5_idle", 32'(tx_idle), 32'(1));
        cyc(3);
        dev_clk = 1'b1;
        reset   = 1'b1;
        cyc(30);
        check("t5_no_tick", 32'(done_cnt - base), 32'(0));
        base = done_cnt;
        send(8'h3C);
        dev_frame(1'b0, -1, rx, par, stp);
        wait_idle("t5_idle2");
        cyc(20);
        check("t5_rx",   32'(rx), 32'h3C);
        check("t5_par",  32'(par), 32'(1));
        check("t5_err",  32'(tx_err), 32'(0));
        check("t5_done", 32'(done_cnt - base), 32'(1));

        // 6: 2-cycle clock glitch after bit 3 of 0x5A; parity of four ones is 1
        base = done_cnt;
        send(8'h5A);
        dev_frame(1'b0, 3, rx, par, stp);
        wait_idle("t6_idle");
        cyc(20);
        check("t6_rx",   32'(rx), 32'h5A);
        check("t6_par",  32'(par), 32'(1));
        check("t6_stop", 32'(stp), 32'(1));
        check("t6_err",  32'(tx_err), 32'(0));
        check("t6_done", 32'(done_cnt - base), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
